fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters sharing one FIFO write port (2..8).
REQ-002 Parameter DATA_SIZE, default 8: width of each requester's data word and of the FIFO write data.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive accepted writes per grant (1..16).
REQ-004 wr_clk  input  1  single clock; all state updates on rising edge.
REQ-005 wr_rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester write request; bit i held high while requester i has a word on its data lane.
REQ-007 req_data  input  NUM_REQ*DATA_SIZE  packed data lanes; lane i = bits [i*DATA_SIZE +: DATA_SIZE].
REQ-008 full  input  1  FIFO full flag, write-clock domain.
REQ-009 wr_en  output  1  FIFO write enable.
REQ-010 wr_data  output  DATA_SIZE  FIFO write data.
REQ-011 ack  output  NUM_REQ  one-hot; bit i high in the cycle requester i's word is written.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of current owner; 0 when idle.
REQ-013 busy  output  1  high while a grant is held (state BURST).

Function
REQ-014 FSM: two states, IDLE and BURST; state, owner, rr_ptr and burst_cnt are registers.
REQ-015 IDLE, any req bit high: next owner = first i with req[i]=1, searched circularly from rr_ptr; go BURST, burst_cnt=0.
REQ-016 IDLE, req all zero: remain IDLE; rr_ptr unchanged.
REQ-017 wr_en combinational = (state==BURST) & req[owner] & ~full & ~wr_rst.
REQ-018 wr_data = lane[owner], combinational; don't-care value when wr_en=0.
REQ-019 ack = one-hot(owner) when wr_en=1, else all zero.
REQ-020 Each accepted write (wr_en=1) increments burst_cnt by 1.
REQ-021 BURST exit on write with burst_cnt==MAX_BURST-1: next state IDLE, rr_ptr = (owner+1) mod NUM_REQ.
REQ-022 BURST exit on req[owner]=0: next state IDLE, rr_ptr = (owner+1) mod NUM_REQ; no write that cycle.
REQ-023 BURST with req[owner]=1 and full=1: stall; state, owner, burst_cnt hold; grant not released by full.
REQ-024 Latency: req rising in IDLE at cycle N gives busy=1 and first possible write at cycle N+1; one dead IDLE cycle between consecutive grants.
REQ-025 Requests from non-owners during BURST are ignored and produce no ack; requesters hold data until acked.
REQ-026 Fairness: with all requesters continuously requesting and full=0, grants rotate 0,1,2,3,... each receiving exactly MAX_BURST writes per grant.
REQ-027 rr_ptr wraps from NUM_REQ-1 to 0; grant_id = owner in BURST, 0 in IDLE.

Reset
REQ-028 wr_rst high at a rising edge: state=IDLE, owner=0, rr_ptr=0, burst_cnt=0 on that edge, regardless of current state.
REQ-029 While wr_rst is high: wr_en=0, ack=0, busy=0, grant_id=0.
REQ-030 Reset mid-burst abandons the burst; no write is issued in the reset cycle, and priority restarts at requester 0.

Verification
REQ-031 Reset, then req=4'b1111, full=0, MAX_BURST=4 for 40 cycles -> ack bursts 0001 x4, idle, 0010 x4, idle, 0100 x4, idle, 1000 x4, idle, then back to 0001; wr_data matches owner lane each write.
REQ-032 req=4'b0100 only, lane2 counting 1,2,3 on each ack, full=0 -> grant_id=2, wr_data 1,2,3,4 on consecutive cycles, then one idle cycle, then requester 2 re-granted.
REQ-033 Owner 1 mid-burst after 2 writes, full asserted 5 cycles -> wr_en=0 and ack=0 for 5 cycles, busy=1, grant_id=1; after full drops exactly 2 more writes, then release.
REQ-034 Owner 3 drops req after 1 write while req[0] high -> IDLE next cycle, rr_ptr wraps to 0, requester 0 granted the cycle after.
REQ-035 wr_rst asserted for 1 cycle during requester 2's burst with req=4'b0110 -> wr_en=0 in reset cycle, then requester 1 granted first (rr_ptr=0 search), burst count restarts at 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters bursts of up to MAX_BURST
// writes into a single FIFO write port, with one dead cycle between grants.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                           wr_clk,
  input  logic                           wr_rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  input  logic                           full,
  output logic                           wr_en,
  output logic [DATA_SIZE-1:0]           wr_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy
);

  localparam int          IDW = $clog2(NUM_REQ);
  localparam int          CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned NR  = NUM_REQ;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;

  logic [DATA_SIZE-1:0] lane [NUM_REQ];
  logic                 req_owner;
  logic                 found;
  logic [IDW-1:0]       pick;
  logic [IDW-1:0]       owner_next;
  int unsigned          idx;

  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      lane[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  assign req_owner  = req[owner_q];
  assign owner_next = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Circular priority search starting at rr_ptr; first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(rr_ptr_q) + k) % NR;
      if (!found && req[IDW'(idx)]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = BURST;
          owner_d     = pick;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (!req_owner) begin
          state_d  = IDLE;
          rr_ptr_d = owner_next;
        end else if (!full) begin
          if (burst_cnt_q == CW'(MAX_BURST - 1)) begin
            state_d     = IDLE;
            rr_ptr_d    = owner_next;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign wr_en    = (state_q == BURST) && req_owner && !full && !wr_rst;
  assign wr_data  = lane[owner_q];
  assign busy     = (state_q == BURST) && !wr_rst;
  assign grant_id = busy ? owner_q : '0;

  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      ack[i] = wr_en && (32'(owner_q) == i);
    end
  end

endmodule
